// File: rtl/vga_pkg.sv
// Shared VGA raster constants, totals helpers and the RGB444 pixel type.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_POL = 1'b0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the renderer and sync pins.
// Carries tp_red/tp_green/tp_blue only when VGA_TESTPATTERN_EN is defined.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic             pix_ce;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             active;
  logic             line_start;
  logic             frame_start;
`ifdef VGA_TESTPATTERN_EN
  logic [3:0]       tp_red;
  logic [3:0]       tp_green;
  logic [3:0]       tp_blue;
`endif

  modport master (
    output pix_ce, hcount, vcount, hsync, vsync, active, line_start, frame_start
`ifdef VGA_TESTPATTERN_EN
    , output tp_red, tp_green, tp_blue
`endif
  );

  modport slave (
    input pix_ce, hcount, vcount, hsync, vsync, active, line_start, frame_start
`ifdef VGA_TESTPATTERN_EN
    , input tp_red, tp_green, tp_blue
`endif
  );

endinterface

// File: rtl/vga_clk_en.sv
// Pixel clock-enable divider: counts 0..CLK_DIV-1 and flags the wrapping clk.
module vga_clk_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic o_wrap,
  output logic o_pix_ce
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_pix_ce;
  logic             w_wrap;

  assign w_wrap = en && (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_pix_ce <= 1'b0;
    end else if (!en) begin
      r_div    <= '0;
      r_pix_ce <= 1'b0;
    end else begin
      r_div    <= w_wrap ? '0 : r_div + DIV_W'(1);
      r_pix_ce <= w_wrap;
    end
  end

  assign o_wrap   = w_wrap;
  assign o_pix_ce = r_pix_ce;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing driven by a pixel clock-enable on the system clock.
// Optional colour-bar test pattern outputs when VGA_TESTPATTERN_EN is defined.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 1024) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 10-bit counter range");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 10-bit counter range");
  end
  if (CLK_DIV < 1) begin : g_div_chk
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic w_wrap;
  logic w_pix_ce;

  vga_clk_en #(.CLK_DIV(CLK_DIV)) u_clk_en (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .o_wrap   (w_wrap),
    .o_pix_ce (w_pix_ce)
  );

  logic [CNT_W-1:0] r_hcount, r_vcount;
  logic [CNT_W-1:0] w_h_next, w_v_next;
  logic             r_hsync, r_vsync, r_active, r_line_start, r_frame_start;
  logic             w_hsync_next, w_vsync_next, w_active_next, w_line_next, w_frame_next;

  always_comb begin
    w_h_next = r_hcount;
    w_v_next = r_vcount;
    if (w_wrap) begin
      if (r_hcount == H_LAST) begin
        w_h_next = '0;
        w_v_next = (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
      end else begin
        w_h_next = r_hcount + 1'b1;
      end
    end
  end

  // Decode from the next counter values so flags register on the same edge as the counters.
  always_comb begin
    w_hsync_next  = ((w_h_next >= HS_LO) && (w_h_next <= HS_HI)) ? SYNC_POL : ~SYNC_POL;
    w_vsync_next  = ((w_v_next >= VS_LO) && (w_v_next <= VS_HI)) ? SYNC_POL : ~SYNC_POL;
    w_active_next = (w_h_next < H_ACT) && (w_v_next < V_ACT);
    w_line_next   = w_wrap && (w_h_next == '0);
    w_frame_next  = w_line_next && (w_v_next == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_active      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (!en) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_active      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_h_next;
      r_vcount      <= w_v_next;
      r_hsync       <= w_hsync_next;
      r_vsync       <= w_vsync_next;
      r_active      <= w_active_next;
      r_line_start  <= w_line_next;
      r_frame_start <= w_frame_next;
    end
  end

  assign vga.pix_ce      = w_pix_ce;
  assign vga.hcount      = r_hcount;
  assign vga.vcount      = r_vcount;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.active      = r_active;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;

`ifdef VGA_TESTPATTERN_EN
  // Eight 80-pixel bars; bar index bits select red/green/blue.
  rgb444_t    w_tp, r_tp;
  logic [2:0] w_bar;

  always_comb begin
    w_bar = 3'(w_h_next / CNT_W'(80));
    w_tp  = '0;
    if (w_active_next) begin
      w_tp.r = {4{w_bar[0]}};
      w_tp.g = {4{w_bar[1]}};
      w_tp.b = {4{w_bar[2]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tp <= '0;
    end else if (!en) begin
      r_tp <= '0;
    end else begin
      r_tp <= w_tp;
    end
  end

  assign vga.tp_red   = r_tp.r;
  assign vga.tp_green = r_tp.g;
  assign vga.tp_blue  = r_tp.b;
`endif

endmodule
